// File: rtl/laplace_stream_filter.sv
// Streaming 3x3 Laplacian filter: two column-indexed line buffers feed a sliding
// 3x3 window; one registered output per accepted input, borders forced to zero.
module laplace_stream_filter #(
  parameter int PIX_W      = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int KERNEL8    = 0,
  parameter int APPROX_LSB = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic [PIX_W-1:0] out_pixel
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW = PIX_W + 3;
  localparam int DW = PIX_W + 4;
  localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
  localparam logic [PIX_W-1:0] LMASK = PIX_W'((1 << APPROX_LSB) - 1);

  typedef enum logic [1:0] {WAIT_SOF, FILL, RUN, FLUSH} state_t;
  state_t state, state_nx;

  logic                         armed;
  logic [CW-1:0]                ic, oc, col_a;
  logic [RW-1:0]                irow, orow;
  logic [PIX_W-1:0]             lb0 [IMG_W];
  logic [PIX_W-1:0]             lb1 [IMG_W];
  logic [2:0][2:0][PIX_W-1:0]   win, nwin;

  logic slot, acc, store, fill_done, last_in, produce, flush_emit, emit;
  logic border, last_out;

  assign slot       = !out_valid || out_ready;
  assign in_ready   = armed && (state != FLUSH) && slot;
  assign acc        = in_valid && in_ready;
  assign store      = acc && (in_sof || state != WAIT_SOF);
  assign col_a      = in_sof ? '0 : ic;
  assign fill_done  = (irow == RW'(1)) && (ic == CW'(1));
  assign last_in    = (irow == RMAX) && (ic == CMAX);
  assign produce    = store && !in_sof && (state == RUN || (state == FILL && fill_done));
  assign flush_emit = (state == FLUSH) && slot;
  assign emit       = produce || flush_emit;
  assign border     = (orow == '0) || (orow == RMAX) || (oc == '0) || (oc == CMAX);
  assign last_out   = (orow == RMAX) && (oc == CMAX);

  // Window rows: [0]=top (two lines back), [1]=middle, [2]=bottom (current line).
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nwin[r][0] = win[r][1];
      nwin[r][1] = win[r][2];
    end
    nwin[0][2] = lb0[col_a];
    nwin[1][2] = lb1[col_a];
    nwin[2][2] = in_pixel;
  end

  // Low APPROX_LSB bits are OR'ed with no carry out; upper bits add exactly.
  function automatic logic [PIX_W:0] padd(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y);
    logic [PIX_W:0] lo, hi;
    lo = {1'b0, (x | y) & LMASK};
    hi = ({1'b0, x >> APPROX_LSB} + {1'b0, y >> APPROX_LSB}) << APPROX_LSB;
    return hi | lo;
  endfunction

  logic [PIX_W:0]        p_bd, p_fh, p_ac, p_gi;
  logic [SW-1:0]         sum;
  logic signed [DW-1:0]  diff, ctr;
  logic [PIX_W-1:0]      sat;

  always_comb begin
    p_bd = padd(nwin[0][1], nwin[1][0]);
    p_fh = padd(nwin[1][2], nwin[2][1]);
    p_ac = padd(nwin[0][0], nwin[0][2]);
    p_gi = padd(nwin[2][0], nwin[2][2]);
    sum  = SW'(p_bd) + SW'(p_fh);
    if (KERNEL8 != 0) sum = sum + SW'(p_ac) + SW'(p_gi);
    ctr  = signed'(DW'(nwin[1][1]) << ((KERNEL8 != 0) ? 3 : 2));
    diff = signed'(DW'(sum)) - ctr;
    if (diff[DW-1])               sat = '0;
    else if (|diff[DW-2:PIX_W])   sat = '1;
    else                          sat = diff[PIX_W-1:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_SOF: if (store) state_nx = FILL;
      FILL:     if (store && !in_sof && fill_done) state_nx = RUN;
      RUN: begin
        if (store && in_sof)       state_nx = FILL;
        else if (store && last_in) state_nx = FLUSH;
      end
      FLUSH:    if (flush_emit && last_out) state_nx = WAIT_SOF;
      default:  state_nx = WAIT_SOF;
    endcase
  end

  // Line buffers: read-before-write on the same column, contents need no reset.
  always_ff @(posedge clk) begin
    if (store) begin
      lb0[col_a] <= lb1[col_a];
      lb1[col_a] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_SOF;
      armed     <= 1'b0;
      ic        <= '0;
      irow      <= '0;
      oc        <= '0;
      orow      <= '0;
      win       <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_pixel <= '0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (store) begin
        win <= nwin;
        if (in_sof) begin
          ic   <= CW'(1);
          irow <= '0;
        end else if (ic == CMAX) begin
          ic   <= '0;
          irow <= (irow == RMAX) ? '0 : irow + 1'b1;
        end else begin
          ic <= ic + 1'b1;
        end
      end
      if (store && in_sof) begin
        oc   <= '0;
        orow <= '0;
      end else if (emit) begin
        if (oc == CMAX) begin
          oc   <= '0;
          orow <= (orow == RMAX) ? '0 : orow + 1'b1;
        end else begin
          oc <= oc + 1'b1;
        end
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_sof   <= (oc == '0) && (orow == '0);
        out_pixel <= (border || state == FLUSH) ? '0 : sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
      end
    end
  end
endmodule
